// File: rtl/img_sobel_3x3_if.sv
// img_sobel_3x3_if: pixel-column input and binary-pixel output bundle for the Sobel stage.
// master: drives valid_i, last/cur/next_img_data[23:0]; receives valid_o, img_data_o[23:0], eof_o.
// slave:  the Sobel stage side.
interface img_sobel_3x3_if;
    logic        valid_i;
    logic [23:0] last_img_data;
    logic [23:0] cur_img_data;
    logic [23:0] next_img_data;
    logic        valid_o;
    logic [23:0] img_data_o;
    logic        eof_o;

    modport master (
        output valid_i, last_img_data, cur_img_data, next_img_data,
        input  valid_o, img_data_o, eof_o
    );

    modport slave (
        input  valid_i, last_img_data, cur_img_data, next_img_data,
        output valid_o, img_data_o, eof_o
    );
endinterface

// File: rtl/img_sobel_3x3.sv
// img_sobel_3x3: 3x3 Sobel |Gx|+|Gy| edge stage over three aligned row streams, thresholded to a binary pixel.
// Ports: clk; reset (sync, active-high); threshold[7:0] (edge threshold, applied every cycle);
//   bus (slave): valid_i, last/cur/next_img_data[23:0] in (luma in [7:0]);
//   valid_o, img_data_o[23:0] = {3{pix8}}, eof_o (with the last pixel of a frame) out.
// Build option SOBEL_GRAD_OUT_EN: output the saturated gradient magnitude instead of the thresholded pixel.
// Pipeline: S1 window + position, S2 Gx/Gy + border flag, S3 magnitude/threshold -> outputs (3 clk latency).
module img_sobel_3x3 #(
    parameter int IMG_WIDTH  = 1280,
    parameter int IMG_HEIGHT = 720
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     threshold,
    img_sobel_3x3_if.slave bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    // Window rows: 0 = top (last), 2 = bottom (next); columns: 0 = oldest, 2 = newest.
    logic [2:0][2:0][7:0] win_d, win_q;
    // Position of the next input beat.
    logic [CW-1:0] col_d, col_q;
    logic [RW-1:0] row_d, row_q;
    logic s1_vld_d, s1_vld_q, s1_border_d, s1_border_q, s1_eof_d, s1_eof_q;
    logic signed [10:0] gx_d, gx_q, gy_d, gy_q;
    logic s2_vld_d, s2_vld_q, s2_border_d, s2_border_q, s2_eof_d, s2_eof_q;
    logic vld_o_d, vld_o_q, eof_o_d, eof_o_q;
    logic [23:0] data_o_d, data_o_q;
    logic [10:0] abs_gx, abs_gy;
    logic [11:0] mag;
    logic [7:0]  sat8, pix8;
    logic        unused_hi;

    function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

`ifdef SOBEL_GRAD_OUT_EN
    assign unused_hi = ^{bus.last_img_data[23:8], bus.cur_img_data[23:8], bus.next_img_data[23:8], threshold};
`else
    assign unused_hi = ^{bus.last_img_data[23:8], bus.cur_img_data[23:8], bus.next_img_data[23:8]};
`endif

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        s1_border_d = s1_border_q;
        s1_eof_d    = s1_eof_q;
        s1_vld_d    = bus.valid_i;
        if (bus.valid_i) begin
            col_d       = col_q == COL_LAST ? '0 : col_q + 1'b1;
            row_d       = col_q != COL_LAST ? row_q : row_q == ROW_LAST ? '0 : row_q + 1'b1;
            win_d[0]    = {bus.last_img_data[7:0], win_q[0][2:1]};
            win_d[1]    = {bus.cur_img_data[7:0], win_q[1][2:1]};
            win_d[2]    = {bus.next_img_data[7:0], win_q[2][2:1]};
            // Columns before 2 hold stale data from the previous line, so they are masked.
            s1_border_d = col_q < CW'(2) || row_q == '0 || row_q == ROW_LAST;
            s1_eof_d    = col_q == COL_LAST && row_q == ROW_LAST;
        end
        gx_d        = gx_q;
        gy_d        = gy_q;
        s2_border_d = s2_border_q;
        s2_eof_d    = s2_eof_q;
        s2_vld_d    = s1_vld_q;
        if (s1_vld_q) begin
            gx_d        = $signed({1'b0, wsum(win_q[0][2], win_q[1][2], win_q[2][2])})
                        - $signed({1'b0, wsum(win_q[0][0], win_q[1][0], win_q[2][0])});
            gy_d        = $signed({1'b0, wsum(win_q[2][0], win_q[2][1], win_q[2][2])})
                        - $signed({1'b0, wsum(win_q[0][0], win_q[0][1], win_q[0][2])});
            s2_border_d = s1_border_q;
            s2_eof_d    = s1_eof_q;
        end
        abs_gx   = gx_q[10] ? $unsigned(-gx_q) : $unsigned(gx_q);
        abs_gy   = gy_q[10] ? $unsigned(-gy_q) : $unsigned(gy_q);
        mag      = {1'b0, abs_gx} + {1'b0, abs_gy};
        sat8     = |mag[11:8] ? 8'hFF : mag[7:0];
`ifdef SOBEL_GRAD_OUT_EN
        pix8     = s2_border_q ? 8'h00 : sat8;
`else
        pix8     = s2_border_q ? 8'h00 : sat8 > threshold ? 8'hFF : 8'h00;
`endif
        vld_o_d  = s2_vld_q;
        eof_o_d  = s2_vld_q && s2_eof_q;
        data_o_d = s2_vld_q ? {3{pix8}} : data_o_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_border_q <= 1'b0;
            s1_eof_q    <= 1'b0;
            gx_q        <= '0;
            gy_q        <= '0;
            s2_vld_q    <= 1'b0;
            s2_border_q <= 1'b0;
            s2_eof_q    <= 1'b0;
            vld_o_q     <= 1'b0;
            eof_o_q     <= 1'b0;
            data_o_q    <= '0;
        end else begin
            win_q       <= win_d;
            col_q       <= col_d;
            row_q       <= row_d;
            s1_vld_q    <= s1_vld_d;
            s1_border_q <= s1_border_d;
            s1_eof_q    <= s1_eof_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            s2_vld_q    <= s2_vld_d;
            s2_border_q <= s2_border_d;
            s2_eof_q    <= s2_eof_d;
            vld_o_q     <= vld_o_d;
            eof_o_q     <= eof_o_d;
            data_o_q    <= data_o_d;
        end
    end

    assign bus.valid_o    = vld_o_q;
    assign bus.eof_o      = eof_o_q;
    assign bus.img_data_o = data_o_q;
endmodule
